// File: rtl/rob_pkg.sv
//------------------------------------------------------------------------------
// Module      : rob_pkg
// Description : Shared types and default widths for the reorder-buffer tracker.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rob_pkg;

    localparam int ROB_DEPTH_DEFAULT = 16;
    localparam int TAG_W_DEFAULT     = $clog2(ROB_DEPTH_DEFAULT);
    localparam int AREG_W            = 5;
    localparam int DATA_W            = 64;
    localparam int PC_W              = 64;

    typedef logic [TAG_W_DEFAULT-1:0] rob_tag_t;

    // One reorder-buffer record in the default configuration.
    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dest;
        logic [AREG_W-1:0] dest;
        logic [DATA_W-1:0] value;
        logic [PC_W-1:0]   pc;
    } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/rob_ptr_ctr.sv
//------------------------------------------------------------------------------
// Module      : rob_ptr_ctr
// Description : Wrapping pointer with increment enable and synchronous clear.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rob_ptr_ctr
    import rob_pkg::*;
#(
    parameter int W = TAG_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Clear wins over increment; wrap is the natural W-bit rollover.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/rob_tracker.sv
//------------------------------------------------------------------------------
// Module      : rob_tracker
// Description : Circular reorder buffer: in-order alloc, out-of-order complete,
//               in-order retire. Optional result forwarding via ROB_FORWARD_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rob_tracker
    import rob_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
    parameter int TAG_W     = $clog2(ROB_DEPTH),
    parameter int AREG_W    = rob_pkg::AREG_W,
    parameter int DATA_W    = rob_pkg::DATA_W,
    parameter int PC_W      = rob_pkg::PC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic              alloc_has_dest,
    input  logic [AREG_W-1:0] alloc_dest,
    input  logic [PC_W-1:0]   alloc_pc,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic              rob_full,
    output logic              rob_empty,
    output logic [TAG_W:0]    rob_count,
    input  logic              complete_valid,
    input  logic [TAG_W-1:0]  complete_tag,
    input  logic [DATA_W-1:0] complete_value,
    output logic              retire_valid,
    output logic              retire_has_dest,
    output logic [AREG_W-1:0] retire_dest,
    output logic [DATA_W-1:0] retire_value,
    output logic [PC_W-1:0]   retire_pc,
    input  logic              flush
`ifdef ROB_FORWARD_EN
    ,
    input  logic [TAG_W-1:0]  fwd_tag,
    output logic              fwd_ready,
    output logic [DATA_W-1:0] fwd_value
`endif
);

    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;
    logic [TAG_W:0]    count_d;

    logic              valid_q    [ROB_DEPTH];
    logic              done_q     [ROB_DEPTH];
    logic              has_dest_q [ROB_DEPTH];
    logic [AREG_W-1:0] dest_q     [ROB_DEPTH];
    logic [DATA_W-1:0] value_q    [ROB_DEPTH];
    logic [PC_W-1:0]   pc_q       [ROB_DEPTH];

    logic              full_w;
    logic              empty_w;
    logic              alloc_accept_w;
    logic              head_ready_w;
    logic              retire_fire_w;
    logic              complete_hit_w;

    assign full_w         = (count_q == (TAG_W+1)'(ROB_DEPTH));
    assign empty_w        = (count_q == '0);
    assign alloc_accept_w = alloc_valid && !full_w && !flush;
    assign head_ready_w   = valid_q[head_q] && done_q[head_q];
    assign retire_fire_w  = head_ready_w && !flush;
    assign complete_hit_w = complete_valid && valid_q[complete_tag] && !flush;

    rob_ptr_ctr #(.W(TAG_W)) u_head_ptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (flush),
        .en_i  (retire_fire_w),
        .ptr_o (head_q)
    );

    rob_ptr_ctr #(.W(TAG_W)) u_tail_ptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (flush),
        .en_i  (alloc_accept_w),
        .ptr_o (tail_q)
    );

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + (TAG_W+1)'(alloc_accept_w) - (TAG_W+1)'(retire_fire_w);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Status bits. Write order matters: a retire clear must win over a late
    // completion to the same slot; alloc never collides since tail is invalid.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
            end
        end else begin
            if (complete_hit_w) begin
                done_q[complete_tag] <= 1'b1;
            end
            if (retire_fire_w) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
            if (alloc_accept_w) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
            end
        end
    end

    // Payload survives a flush; only reset scrubs it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                has_dest_q[i] <= 1'b0;
                dest_q[i]     <= '0;
                value_q[i]    <= '0;
                pc_q[i]       <= '0;
            end
        end else if (!flush) begin
            if (complete_hit_w) begin
                value_q[complete_tag] <= complete_value;
            end
            if (alloc_accept_w) begin
                has_dest_q[tail_q] <= alloc_has_dest;
                dest_q[tail_q]     <= alloc_dest;
                pc_q[tail_q]       <= alloc_pc;
            end
        end
    end

    assign alloc_tag       = tail_q;
    assign rob_full        = full_w;
    assign rob_empty       = empty_w;
    assign rob_count       = count_q;
    assign retire_valid    = head_ready_w;
    assign retire_has_dest = has_dest_q[head_q];
    assign retire_dest     = dest_q[head_q];
    assign retire_value    = value_q[head_q];
    assign retire_pc       = pc_q[head_q];

`ifdef ROB_FORWARD_EN
    logic fwd_bypass_w;

    // A completion landing this very cycle is visible to the reader at once.
    assign fwd_bypass_w = complete_valid && (complete_tag == fwd_tag);
    assign fwd_ready    = valid_q[fwd_tag] && (done_q[fwd_tag] || fwd_bypass_w);
    assign fwd_value    = fwd_bypass_w ? complete_value : value_q[fwd_tag];
`endif

endmodule

`default_nettype wire
